// File: rtl/fpu_mantissa_multiplier.sv
// Three-stage unsigned 24x24 -> 48-bit significand multiplier for the FP multiply path.
// Two 27x18 multiply-accumulate steps (low then high partial); a tag rides along with each operation.
module fpu_mantissa_multiplier #(
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [23:0]          in_a,
  input  logic [23:0]          in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [47:0]          out_product,
  output logic                 out_msb,
  output logic [TAG_WIDTH-1:0] out_tag
);

  // Handshake: a transfer happens on a rising edge where valid && ready on that side.
  // The producer holds valid and data until the transfer. in_ready depends only on
  // out_ready and the stage valid bits, never on in_valid.

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s3_valid;
  logic                 load1;
  logic                 load2;
  logic                 load3;

  logic [23:0]          s1_a;
  logic [23:0]          s1_b;
  logic [TAG_WIDTH-1:0] s1_tag;

  logic [40:0]          s2_p_lo;
  logic [23:0]          s2_a;
  logic [6:0]           s2_b_hi;
  logic [TAG_WIDTH-1:0] s2_tag;

  logic [47:0]          s3_product;
  logic [TAG_WIDTH-1:0] s3_tag;

  logic [40:0]          p_lo_next;
  logic [30:0]          p_hi_next;

  // A stage advances when it is empty or its successor is advancing (bubble collapse).
  always_comb begin
    load3 = !s3_valid || out_ready;
    load2 = !s2_valid || load3;
    load1 = !s1_valid || load2;
  end

  assign in_ready = load1;

  // Both MAC operands are zero-extended, so the signed 27x18 DSP products are
  // exactly the unsigned products written here.
  assign p_lo_next = {17'b0, s1_a} * {24'b0, s1_b[16:0]};
  // The high step's true value is floor(a*b / 2^17) < 2^31, so 31 bits hold it exactly.
  assign p_hi_next = ({7'b0, s2_a} * {24'b0, s2_b_hi}) + {7'b0, s2_p_lo[40:17]};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (load1) s1_valid <= in_valid;
      if (load2) s2_valid <= s1_valid;
      if (load3) s3_valid <= s2_valid;
    end
  end

  // Data registers are left unreset; they only matter under their stage's valid bit.
  always_ff @(posedge clk) begin
    if (load1) begin
      s1_a   <= in_a;
      s1_b   <= in_b;
      s1_tag <= in_tag;
    end
    if (load2) begin
      s2_p_lo <= p_lo_next;
      s2_a    <= s1_a;
      s2_b_hi <= s1_b[23:17];
      s2_tag  <= s1_tag;
    end
    if (load3) begin
      s3_product <= {p_hi_next, s2_p_lo[16:0]};
      s3_tag     <= s2_tag;
    end
  end

  assign out_valid   = s3_valid;
  assign out_product = s3_product;
  assign out_msb     = s3_product[47];
  assign out_tag     = s3_tag;

endmodule

// File: tb/tb_fpu_mantissa_multiplier.sv
// Bench for fpu_mantissa_multiplier: directed vector table, hand-written stall/reset
// sequences and a long random stream checked against a plain a*b queue model.
module tb_fpu_mantissa_multiplier;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_a;
  logic [23:0] in_b;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_product;
  logic        out_msb;
  logic [7:0]  out_tag;

  fpu_mantissa_multiplier #(.TAG_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_msb     (out_msb),
    .out_tag     (out_tag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  int n_accepted = 0;
  int n_received = 0;
  int in_pct = 0;
  int ready_pct = 0;
  logic took;

  logic [23:0] src_a[$];
  logic [23:0] src_b[$];
  logic [7:0]  src_tag[$];
  logic [55:0] exp_q[$];

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [7:0]  tag;
    logic [47:0] product;
    logic        msb;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact product from plain wide arithmetic.
  function automatic logic [55:0] model(input logic [23:0] a, input logic [23:0] b,
                                        input logic [7:0] tag);
    logic [47:0] wa;
    logic [47:0] wb;
    wa = {24'b0, a};
    wb = {24'b0, b};
    return {tag, wa * wb};
  endfunction

  // ---------------- driver / monitor: one clock cycle ----------------
  task automatic cycle();
    logic [55:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got product %0h tag %0h, expected none", out_product, out_tag);
      end else begin
        e = exp_q.pop_front();
        check("product", {16'b0, out_product}, {16'b0, e[47:0]});
        check("tag", {56'b0, out_tag}, {56'b0, e[55:48]});
        check("msb", {63'b0, out_msb}, {63'b0, e[47]});
        n_received++;
      end
    end
    took = in_valid && in_ready;
    if (took) begin
      exp_q.push_back(model(in_a, in_b, in_tag));
      n_accepted++;
    end
    @(posedge clk);
    #1;
    if (took) begin
      void'(src_a.pop_front());
      void'(src_b.pop_front());
      void'(src_tag.pop_front());
    end
    if (!(in_valid && !took)) begin
      in_valid = (src_a.size() > 0) && ($urandom_range(99) < in_pct);
      if (src_a.size() > 0) begin
        in_a   = src_a[0];
        in_b   = src_b[0];
        in_tag = src_tag[0];
      end
    end
    out_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic push_op(input logic [23:0] a, input logic [23:0] b, input logic [7:0] tag);
    src_a.push_back(a);
    src_b.push_back(b);
    src_tag.push_back(tag);
  endtask

  task automatic drain(input string name, input int budget);
    int cyc;
    cyc = 0;
    while ((src_a.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      cycle();
      cyc++;
    end
    check(name, {63'b0, cyc >= budget}, 64'd0);
  endtask

  // Single op into an empty pipe with out_ready high; checks exact 3-cycle latency.
  task automatic single_op(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_a = v.a; in_b = v.b; in_tag = v.tag; out_ready = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d_in_ready", idx), {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_lat1", idx), {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    check($sformatf("v%0d_lat2", idx), {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    check($sformatf("v%0d_valid", idx), {63'b0, out_valid}, 64'd1);
    check($sformatf("v%0d_product", idx), {16'b0, out_product}, {16'b0, v.product});
    check($sformatf("v%0d_msb", idx), {63'b0, out_msb}, {63'b0, v.msb});
    check($sformatf("v%0d_tag", idx), {56'b0, out_tag}, {56'b0, v.tag});
    @(negedge clk);
    check($sformatf("v%0d_no_dup", idx), {63'b0, out_valid}, 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [55:0] hold;
    vecs[0] = '{24'hFFFFFF, 24'hFFFFFF, 8'h5A, 48'hFFFFFE000001, 1'b1};
    vecs[1] = '{24'h800000, 24'h800000, 8'h01, 48'h400000000000, 1'b0};
    vecs[2] = '{24'hC00000, 24'hC00000, 8'h02, 48'h900000000000, 1'b1};
    vecs[3] = '{24'h000000, 24'hABCDEF, 8'h03, 48'h000000000000, 1'b0};
    vecs[4] = '{24'h000001, 24'hFFFFFF, 8'h04, 48'h000000FFFFFF, 1'b0};
    vecs[5] = '{24'h01FFFF, 24'h020000, 8'h05, 48'h0003FFFE0000, 1'b0};
    vecs[6] = '{24'h020000, 24'h01FFFF, 8'h06, 48'h0003FFFE0000, 1'b0};
    vecs[7] = '{24'hFFFFFF, 24'h01FFFF, 8'h07, 48'h01FFFEFE0001, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_in_ready", {63'b0, in_ready}, 64'd1);

    // Directed vectors, one at a time.
    for (int i = 0; i < 8; i++) single_op(vecs[i], i);

    // Back-to-back: results on consecutive cycles.
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_a = 24'h800000; in_b = 24'h800000; in_tag = 8'hA1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_a = 24'hC00000; in_b = 24'hC00000; in_tag = 8'hA2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_gap", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    check("b2b_first_valid", {63'b0, out_valid}, 64'd1);
    check("b2b_first", {16'b0, out_product}, 64'h400000000000);
    check("b2b_first_msb", {63'b0, out_msb}, 64'd0);
    @(negedge clk);
    check("b2b_second_valid", {63'b0, out_valid}, 64'd1);
    check("b2b_second", {16'b0, out_product}, 64'h900000000000);
    check("b2b_second_msb", {63'b0, out_msb}, 64'd1);
    check("b2b_second_tag", {56'b0, out_tag}, 64'hA2);
    @(posedge clk);
    #1;

    // Stall: 5 ops offered with out_ready low, only 3 fit.
    out_ready = 1'b0;
    in_pct = 100; ready_pct = 0; n_accepted = 0; n_received = 0;
    for (int i = 0; i < 5; i++) push_op(24'($urandom), 24'($urandom), 8'(8'h10 + i));
    repeat (8) cycle();
    check("stall_accepted", n_accepted, 64'd3);
    check("stall_in_ready", {63'b0, in_ready}, 64'd0);
    hold = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_valid", {63'b0, out_valid}, 64'd1);
      check("stall_product", {16'b0, out_product}, {16'b0, hold[47:0]});
      check("stall_tag", {56'b0, out_tag}, {56'b0, hold[55:48]});
    end
    ready_pct = 100;
    drain("stall_drain", 40);
    check("stall_received", n_received, 64'd5);
    check("stall_total_accepted", n_accepted, 64'd5);

    // Reset with three ops in flight.
    ready_pct = 0; out_ready = 1'b0; n_accepted = 0;
    for (int i = 0; i < 3; i++) push_op(24'($urandom), 24'($urandom), 8'(8'h20 + i));
    repeat (5) cycle();
    check("rst_fill", n_accepted, 64'd3);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_mid_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_pct = 0; ready_pct = 100; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("rst_no_stale", {63'b0, out_valid}, 64'd0);
    end

    // Random streams: two phases with different valid/ready densities.
    in_pct = 70; ready_pct = 60;
    for (int i = 0; i < 5000; i++) push_op(24'($urandom), 24'($urandom), 8'($urandom));
    drain("rand_drain_a", 40000);
    in_pct = 95; ready_pct = 30;
    for (int i = 0; i < 5000; i++) begin
      case ($urandom_range(3))
        0:       push_op(24'hFFFFFF, 24'($urandom), 8'($urandom));
        1:       push_op(24'($urandom), 24'h01FFFF + 24'($urandom_range(2)), 8'($urandom));
        default: push_op(24'($urandom), 24'($urandom), 8'($urandom));
      endcase
    end
    drain("rand_drain_b", 40000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_mantissa_multiplier.md
# fpu_mantissa_multiplier

Pipelined unsigned 24x24 -> 48-bit mantissa multiplier for the single-precision FPU multiply path, built from two 27x18 signed multiply-accumulate steps that map one-to-one onto UltraScale DSP48 slices. It sits between operand unpacking (which supplies 24-bit significands with the hidden bit restored) and the normalize/round stage, which consumes the full 48-bit product. It carries a caller-defined tag alongside each product and uses a valid/ready stream on both sides with bubble-collapsing stall behaviour.

## Interface
- TAG_WIDTH, 8, width of the opaque tag carried with each operation (>= 1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous to clk, active-high
- in_valid  input  1  operand pair presented
- in_ready  output  1  block accepts operand pair this cycle
- in_a  input  24  significand A, unsigned
- in_b  input  24  significand B, unsigned
- in_tag  input  TAG_WIDTH  tag, returned unchanged with the result
- out_valid  output  1  product presented
- out_ready  input  1  downstream accepts product this cycle
- out_product  output  48  in_a * in_b, unsigned, exact
- out_msb  output  1  equals out_product[47]; normalization hint (1: product in [2,4), 0: in [1,2) for normalized inputs)
- out_tag  output  TAG_WIDTH  tag of the operation that produced out_product

## Operation
- Three register stages S1, S2, S3, each with its own valid bit.
- S1 (capture): registers a, b, tag. Splits b into b_lo = b[16:0] and b_hi = b[23:17].
- S2 (low partial): p_lo = {3'b0,a} * {1'b0,b_lo} + 0, computed as a 27x18 signed MAC with both operands non-negative; p_lo < 2^41. Registers p_lo, a, b_hi, tag.
- S3 (high partial + accumulate): p_hi = {3'b0,a} * {11'b0,b_hi} + (p_lo >> 17), one 27x18 MAC with 48-bit C input; p_hi < 2^31. Registers out_product = {p_hi[30:0], p_lo[16:0]}, tag.
- All arithmetic unsigned in effect; no rounding, no truncation; result exact for every input pair.
- Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready. out_valid = S3 valid.
- Bubble-collapsing advance: S3 loads when S3 empty or out_ready; S2 loads when S2 empty or S3 loads; S1 loads when S1 empty or S2 loads. in_ready = S1 load condition (combinational from out_ready and valid bits; no combinational path from in_valid to in_ready).
- A stage that loads from an empty predecessor becomes empty. Stalled stages hold data and valid bit unchanged.
- out_product, out_msb and out_tag stable while out_valid && !out_ready.
- Reset: all three valid bits cleared; out_valid = 0; in_ready = 1 in the first cycle after reset; data registers need not be reset (out_product/out_tag don't-care while out_valid = 0).
- Reset mid-operation: all in-flight operations discarded, none emitted after rst deasserts.

## Timing
- Latency: operand accepted in cycle N appears with out_valid = 1 in cycle N+3 if no stall.
- Throughput: one operation per cycle while out_ready held high.
- Capacity: 3 operations in flight; with out_ready low, at most 3 accepted before in_ready drops; in_ready returns high in the same cycle out_ready returns high.
- Simultaneous output transfer and input transfer in a full pipeline: allowed; all stages advance, no bubble.
- Back-to-back with gaps on input: bubbles are squeezed out only while out_ready is low; order of results always equals order of acceptance.

## Test plan
- Single op 0xFFFFFF * 0xFFFFFF, tag 0x5A, out_ready=1 -> 3 cycles later out_product = 0xFFFFFE000001, out_msb = 1, out_tag = 0x5A.
- 0x800000 * 0x800000 then 0xC00000 * 0xC00000 back-to-back -> 0x400000000000 (msb 0) then 0x900000000000 (msb 1) on consecutive cycles.
- Hold out_ready=0, stream 5 ops -> exactly 3 accepted, in_ready = 0 thereafter, outputs stable; release out_ready -> 5 results in order, tags intact, no duplicates.
- Boundary operands: 0 * 0xABCDEF -> 0; 1 * 0xFFFFFF -> 0x000000FFFFFF; 0x01FFFF * 0x020000 (b_lo/b_hi split edge) -> 0x0003FFFE0000.
- Assert rst for one cycle with 3 ops in flight -> out_valid = 0 next cycle, in_ready = 1, no stale result ever emitted.
- Random 10k pairs with random in_valid/out_ready toggling -> every product matches a*b reference model, in order.
